episode_controller: RTL and testbench

EPISODE_CONTROLLER -- requirements
Module: episode_controller

---
 rtl/episode_controller_if.sv | 37 +++
 rtl/episode_controller.sv | 134 +++++++++++++
 tb/tb_episode_controller.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/episode_controller_if.sv
// rtl/episode_controller_if.sv - episode controller control, location and handshake bundle
interface episode_controller_if #(
  parameter int DATA_LENGTH   = 6,
  parameter int STEP_WIDTH    = 8,
  parameter int EPISODE_WIDTH = 16
);
  logic                     start;
  logic [EPISODE_WIDTH-1:0] num_episodes;
  logic [DATA_LENGTH-1:0]   cur_location;
  logic [DATA_LENGTH-1:0]   goal_location;
  logic                     loc_enable;
  logic                     loc_select;
  logic                     step_req;
  logic                     step_ack;
  logic                     learn_req;
  logic                     learn_ack;
  logic                     plan_req;
  logic                     plan_ack;
  logic                     busy;
  logic                     done;
  logic [STEP_WIDTH-1:0]    step_count;
  logic [EPISODE_WIDTH-1:0] episode_count;

  modport master (
    input  start, num_episodes, cur_location, goal_location,
    input  step_ack, learn_ack, plan_ack,
    output loc_enable, loc_select, step_req, learn_req, plan_req,
    output busy, done, step_count, episode_count
  );

  modport slave (
    output start, num_episodes, cur_location, goal_location,
    output step_ack, learn_ack, plan_ack,
    input  loc_enable, loc_select, step_req, learn_req, plan_req,
    input  busy, done, step_count, episode_count
  );
endinterface

// File: rtl/episode_controller.sv
// rtl/episode_controller.sv - training-run sequencer: episodes of step/learn/plan handshakes
module episode_controller #(
  parameter int DATA_LENGTH   = 6,
  parameter int STEP_WIDTH    = 8,
  parameter int EPISODE_WIDTH = 16,
  parameter int MAX_STEPS     = 255,
  parameter int PLAN_STEPS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  episode_controller_if.master bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_STEP  = 3'd2;
  localparam logic [2:0] S_LEARN = 3'd3;
  localparam logic [2:0] S_LATCH = 3'd4;
  localparam logic [2:0] S_PLAN  = 3'd5;
  localparam logic [2:0] S_CHECK = 3'd6;
  localparam logic [2:0] S_FIN   = 3'd7;

  // Plan counter only needs to reach PLAN_STEPS-1; the final ack leaves PLAN directly.
  localparam int PLAN_W = (PLAN_STEPS > 1) ? $clog2(PLAN_STEPS) : 1;
  localparam logic [PLAN_W-1:0]        PLAN_LAST  = PLAN_W'((PLAN_STEPS > 0) ? PLAN_STEPS - 1 : 0);
  localparam logic [PLAN_W-1:0]        PLAN_ONE   = PLAN_W'(1);
  localparam logic [STEP_WIDTH-1:0]    STEP_MAX   = STEP_WIDTH'(MAX_STEPS);
  localparam logic [STEP_WIDTH-1:0]    STEP_ONE   = STEP_WIDTH'(1);
  localparam logic [EPISODE_WIDTH-1:0] EP_ONE     = EPISODE_WIDTH'(1);
  localparam logic                     HAS_PLAN   = (PLAN_STEPS > 0);

  logic [2:0]               state_q, state_d;
  logic [STEP_WIDTH-1:0]    step_q, step_d;
  logic [EPISODE_WIDTH-1:0] ep_q, ep_d;
  logic [EPISODE_WIDTH-1:0] num_q, num_d;
  logic [PLAN_W-1:0]        plan_q, plan_d;

  logic [DATA_LENGTH-1:0]   cur_loc;
  logic [DATA_LENGTH-1:0]   goal_loc;
  logic [EPISODE_WIDTH-1:0] ep_inc;
  logic                     episode_end;

  assign cur_loc     = bus.cur_location;
  assign goal_loc    = bus.goal_location;
  assign ep_inc      = ep_q + EP_ONE;
  assign episode_end = (cur_loc == goal_loc) || (step_q == STEP_MAX);

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    ep_d    = ep_q;
    num_d   = num_q;
    plan_d  = plan_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          num_d   = bus.num_episodes;
          ep_d    = '0;
          state_d = (bus.num_episodes == '0) ? S_FIN : S_LOAD;
        end
      end
      S_LOAD: begin
        step_d  = '0;
        state_d = S_STEP;
      end
      S_STEP: begin
        if (bus.step_ack) begin
          step_d  = step_q + STEP_ONE;
          state_d = S_LEARN;
        end
      end
      S_LEARN: begin
        if (bus.learn_ack) begin
          state_d = S_LATCH;
        end
      end
      S_LATCH: begin
        plan_d  = '0;
        state_d = HAS_PLAN ? S_PLAN : S_CHECK;
      end
      S_PLAN: begin
        if (bus.plan_ack) begin
          if (plan_q == PLAN_LAST) begin
            state_d = S_CHECK;
          end else begin
            plan_d = plan_q + PLAN_ONE;
          end
        end
      end
      // cur_location already reflects the LATCH write by the time CHECK runs.
      S_CHECK: begin
        if (episode_end) begin
          ep_d    = ep_inc;
          state_d = (ep_inc == num_q) ? S_FIN : S_LOAD;
        end else begin
          state_d = S_STEP;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      ep_q    <= '0;
      num_q   <= '0;
      plan_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      ep_q    <= ep_d;
      num_q   <= num_d;
      plan_q  <= plan_d;
    end
  end

  assign bus.loc_enable    = (state_q == S_LOAD) || (state_q == S_LATCH);
  assign bus.loc_select    = (state_q == S_LATCH);
  assign bus.step_req      = (state_q == S_STEP);
  assign bus.learn_req     = (state_q == S_LEARN);
  assign bus.plan_req      = (state_q == S_PLAN);
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.done          = (state_q == S_FIN);
  assign bus.step_count    = step_q;
  assign bus.episode_count = ep_q;

endmodule

// File: tb/tb_episode_controller.sv
// tb/tb_episode_controller.sv - directed vector bench for episode_controller
module tb_episode_controller;

  typedef struct {
    int num;
    int goal;
    int sd;
    int ld;
    int pd;
    int exp_steps;
    int exp_eps;
    int exp_busy;
    int exp_loads;
    int exp_sacks;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  episode_controller_if #(.DATA_LENGTH(6), .STEP_WIDTH(8), .EPISODE_WIDTH(16)) bus_a ();
  episode_controller_if #(.DATA_LENGTH(6), .STEP_WIDTH(8), .EPISODE_WIDTH(16)) bus_b ();

  episode_controller #(.DATA_LENGTH(6), .STEP_WIDTH(8), .EPISODE_WIDTH(16),
                       .MAX_STEPS(4), .PLAN_STEPS(2)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );

  episode_controller #(.DATA_LENGTH(6), .STEP_WIDTH(8), .EPISODE_WIDTH(16),
                       .MAX_STEPS(255), .PLAN_STEPS(0)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  int total = 0;
  int bad = 0;

  // location registers: start location 0, next location = current + 1
  logic [5:0] loc_a = '0;
  logic [5:0] loc_b = '0;
  always @(posedge clk) begin
    if (bus_a.loc_enable) loc_a <= bus_a.loc_select ? loc_a + 6'd1 : 6'd0;
    if (bus_b.loc_enable) loc_b <= bus_b.loc_select ? loc_b + 6'd1 : 6'd0;
  end
  assign bus_a.cur_location = loc_a;
  assign bus_b.cur_location = loc_b;

  // DUT B partner acks immediately
  assign bus_b.step_ack  = bus_b.step_req;
  assign bus_b.learn_ack = bus_b.learn_req;
  assign bus_b.plan_ack  = bus_b.plan_req;

  int sd = 0, ld = 0, pd = 0;
  int s_cnt = 0, l_cnt = 0, p_cnt = 0;
  logic auto_s = 1'b0, auto_l = 1'b0, auto_p = 1'b0;
  logic manual = 1'b0;
  logic man_s = 1'b0, man_l = 1'b0, man_p = 1'b0;

  assign bus_a.step_ack  = manual ? man_s : auto_s;
  assign bus_a.learn_ack = manual ? man_l : auto_l;
  assign bus_a.plan_ack  = manual ? man_p : auto_p;

  always @(posedge clk) begin
    #1;
    if (bus_a.step_req) begin
      if (s_cnt >= sd) begin auto_s = 1'b1; s_cnt = 0; end
      else begin auto_s = 1'b0; s_cnt++; end
    end else begin auto_s = 1'b0; s_cnt = 0; end
    if (bus_a.learn_req) begin
      if (l_cnt >= ld) begin auto_l = 1'b1; l_cnt = 0; end
      else begin auto_l = 1'b0; l_cnt++; end
    end else begin auto_l = 1'b0; l_cnt = 0; end
    if (bus_a.plan_req) begin
      if (p_cnt >= pd) begin auto_p = 1'b1; p_cnt = 0; end
      else begin auto_p = 1'b0; p_cnt++; end
    end else begin auto_p = 1'b0; p_cnt = 0; end
  end

  logic mon_clr = 1'b0;
  int m_busy = 0, m_done = 0, m_loads = 0, m_sacks = 0, m_reqs = 0, m_viol = 0;
  logic p_s_req = 1'b0, p_s_ack = 1'b0, p_l_req = 1'b0, p_l_ack = 1'b0, p_p_req = 1'b0, p_p_ack = 1'b0;
  int b_busy = 0, b_plan = 0;

  always @(negedge clk) begin
    if (mon_clr) begin
      m_busy = 0; m_done = 0; m_loads = 0; m_sacks = 0; m_reqs = 0; m_viol = 0;
    end else begin
      if (bus_a.busy) m_busy++;
      if (bus_a.done) m_done++;
      if (bus_a.loc_enable && !bus_a.loc_select) m_loads++;
      if (bus_a.step_req && bus_a.step_ack) m_sacks++;
      if (bus_a.step_req || bus_a.learn_req || bus_a.plan_req) m_reqs++;
      if (reset) begin
        if (p_s_req && !p_s_ack && !bus_a.step_req) m_viol++;
        if (p_l_req && !p_l_ack && !bus_a.learn_req) m_viol++;
        if (p_p_req && !p_p_ack && !bus_a.plan_req) m_viol++;
        if (bus_a.learn_req && !p_l_req && !(p_s_req && p_s_ack)) m_viol++;
      end
    end
    p_s_req = bus_a.step_req;  p_s_ack = bus_a.step_ack;
    p_l_req = bus_a.learn_req; p_l_ack = bus_a.learn_ack;
    p_p_req = bus_a.plan_req;  p_p_ack = bus_a.plan_ack;
    if (bus_b.busy) b_busy++;
    if (bus_b.plan_req) b_plan++;
  end

  task automatic check(input string name, input int actual, input int required);
    total++;
    if (actual != required) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  task automatic wait_done_a(input string name);
    int n;
    n = 0;
    while (!bus_a.done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int n;
    sd = v.sd; ld = v.ld; pd = v.pd;
    bus_a.goal_location = 6'(v.goal);
    @(posedge clk); mon_clr = 1'b1;
    @(posedge clk); mon_clr = 1'b0;
    @(negedge clk);
    bus_a.start = 1'b1;
    bus_a.num_episodes = 16'(v.num);
    @(negedge clk);
    bus_a.start = 1'b0;
    bus_a.num_episodes = 16'(v.num + 5);
    if (v.num != 0) begin
      repeat (2) @(negedge clk);
      bus_a.start = 1'b1;
      @(negedge clk);
      bus_a.start = 1'b0;
    end
    n = 0;
    while (m_done == 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check({name, "_timeout"}, 0, 1);
    repeat (3) @(negedge clk);
    check({name, "_steps"}, int'(bus_a.step_count), v.exp_steps);
    check({name, "_episodes"}, int'(bus_a.episode_count), v.exp_eps);
    check({name, "_done_pulses"}, m_done, 1);
    check({name, "_busy_cycles"}, m_busy, v.exp_busy);
    check({name, "_loads"}, m_loads, v.exp_loads);
    check({name, "_step_acks"}, m_sacks, v.exp_sacks);
    check({name, "_req_hold"}, m_viol, 0);
    if (v.num == 0) check({name, "_no_req"}, m_reqs, 0);
  endtask

  vec_t vecs[6];

  initial begin
    int n;
    vecs[0] = '{0, 5, 0, 0, 0, 0, 0, 1, 0, 0};
    vecs[1] = '{1, 3, 0, 0, 0, 3, 1, 20, 1, 3};
    vecs[2] = '{2, 63, 0, 0, 0, 4, 2, 51, 2, 8};
    vecs[3] = '{1, 2, 3, 7, 0, 2, 1, 34, 1, 2};
    vecs[4] = '{1, 1, 7, 3, 3, 1, 1, 24, 1, 1};
    vecs[5] = '{3, 2, 0, 0, 0, 2, 3, 40, 3, 6};

    bus_a.start = 1'b0; bus_a.num_episodes = '0; bus_a.goal_location = '0;
    bus_b.start = 1'b0; bus_b.num_episodes = '0; bus_b.goal_location = 6'd2;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ctrl_outputs", int'({bus_a.busy, bus_a.done, bus_a.loc_enable, bus_a.loc_select}), 0);
    check("rst_reqs", int'({bus_a.step_req, bus_a.learn_req, bus_a.plan_req}), 0);
    check("rst_counts", int'(bus_a.step_count) + int'(bus_a.episode_count), 0);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_after_release", int'(bus_a.busy), 0);

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // acks outside their own state must be ignored
    sd = 0; ld = 0; pd = 0;
    bus_a.goal_location = 6'd1;
    @(negedge clk);
    manual = 1'b1; man_s = 1'b1; man_l = 1'b1; man_p = 1'b1;
    repeat (3) @(negedge clk);
    check("spur_idle_busy", int'(bus_a.busy), 0);
    check("spur_idle_reqs", int'({bus_a.step_req, bus_a.learn_req, bus_a.plan_req}), 0);
    man_s = 1'b0; man_l = 1'b0; man_p = 1'b0;
    bus_a.start = 1'b1; bus_a.num_episodes = 16'd1;
    @(negedge clk);
    bus_a.start = 1'b0;
    man_l = 1'b1; man_p = 1'b1;
    repeat (3) @(negedge clk);
    check("spur_step_hold", int'({bus_a.step_req, bus_a.learn_req}), 2);
    check("spur_step_count", int'(bus_a.step_count), 0);
    man_s = 1'b1; man_l = 1'b0; man_p = 1'b0;
    @(negedge clk);
    check("spur_learn_entry", int'({bus_a.step_req, bus_a.learn_req}), 1);
    check("spur_learn_count", int'(bus_a.step_count), 1);
    repeat (2) @(negedge clk);
    check("spur_learn_hold", int'(bus_a.learn_req), 1);
    check("spur_learn_count2", int'(bus_a.step_count), 1);
    man_s = 1'b0;
    manual = 1'b0;
    wait_done_a("spur");
    @(negedge clk);
    check("spur_final_steps", int'(bus_a.step_count), 1);
    check("spur_final_eps", int'(bus_a.episode_count), 1);

    // asynchronous reset while PLAN holds plan counter = 1
    bus_a.goal_location = 6'd63;
    bus_a.start = 1'b1; bus_a.num_episodes = 16'd1;
    @(negedge clk);
    bus_a.start = 1'b0;
    n = 0;
    while (!bus_a.plan_req && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("plan_reach_timeout", 0, 1);
    @(negedge clk);
    check("pre_rst_plan_req", int'(bus_a.plan_req), 1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_reqs", int'({bus_a.step_req, bus_a.learn_req, bus_a.plan_req}), 0);
    check("async_rst_busy", int'(bus_a.busy), 0);
    check("async_rst_step_count", int'(bus_a.step_count), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_idle", int'(bus_a.busy), 0);
    run_vec(vecs[1], "post_rst");

    // build without planning
    @(negedge clk);
    bus_b.start = 1'b1; bus_b.num_episodes = 16'd1;
    @(negedge clk);
    bus_b.start = 1'b0;
    n = 0;
    while (!bus_b.done && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("noplan_timeout", 0, 1);
    repeat (2) @(negedge clk);
    check("noplan_busy_cycles", b_busy, 10);
    check("noplan_plan_req", b_plan, 0);
    check("noplan_steps", int'(bus_b.step_count), 2);
    check("noplan_eps", int'(bus_b.episode_count), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
